// File: rtl/led_status_bank.sv
// led_status_bank: per-channel LED hold timers with blink, retrigger and exclusive-winner arbitration.
module led_status_bank #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tick_1s,
  input  logic [NUM_CH-1:0]       event_pulse,
  input  logic [NUM_CH*CNT_W-1:0] hold_sec,
  input  logic [NUM_CH-1:0]       blink_mode,
  input  logic                    exclusive,
  output logic [NUM_CH-1:0]       led,
  output logic [NUM_CH-1:0]       active,
  output logic                    any_active
);
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [NUM_CH-1:0] ph_q, ph_d, acc, win;
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) acc[i] = event_pulse[i] && hold_sec[i*CNT_W +: CNT_W] != '0;
    win = acc & (~acc + NUM_CH'(1));
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      ph_d[i]  = ph_q[i];
      if (acc[i] && (!exclusive || win[i])) begin
        cnt_d[i] = hold_sec[i*CNT_W +: CNT_W];
        ph_d[i]  = 1'b1;
      end else if (exclusive && |acc) begin
        cnt_d[i] = '0;
        ph_d[i]  = 1'b0;
      end else if (tick_1s && cnt_q[i] != '0) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
        ph_d[i]  = ~ph_q[i];
      end
    end
  end
  always_ff @(posedge clk) begin
    ph_q <= reset ? '0 : ph_d;
    for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= reset ? '0 : cnt_d[i];
  end
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      active[i] = cnt_q[i] != '0;
      led[i]    = active[i] && (!blink_mode[i] || ph_q[i]);
    end
  end
  assign any_active = |active;
endmodule

// File: tb/tb_led_status_bank.sv
// tb_led_status_bank: directed plus random stimulus against a seconds-remaining reference model, checked through a scoreboard queue.
module tb_led_status_bank;
  localparam int N = 4;
  localparam int W = 4;
  typedef struct packed {
    logic [N-1:0] led;
    logic [N-1:0] act;
    logic         any;
  } exp_t;

  logic clk = 0;
  logic reset = 1, tick_1s = 0, exclusive = 0;
  logic [N-1:0] event_pulse = '0, blink_mode = '0, led, active;
  logic [N*W-1:0] hold_sec = '0;
  logic any_active;

  led_status_bank #(.NUM_CH(N), .CNT_W(W)) dut (
    .clk(clk), .reset(reset), .tick_1s(tick_1s), .event_pulse(event_pulse),
    .hold_sec(hold_sec), .blink_mode(blink_mode), .exclusive(exclusive),
    .led(led), .active(active), .any_active(any_active)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int checks = 0, failures = 0;
  int rem [N];
  bit on [N];
  bit done = 0;
  logic r, tk, ex;
  logic [N-1:0] ev, bm;
  logic [N*W-1:0] hs;

  task automatic chk(string name, logic [N-1:0] got, logic [N-1:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, got, want);
    end
  endtask

  task automatic step();
    exp_t e;
    int w;
    @(negedge clk);
    reset = r; tick_1s = tk; event_pulse = ev; hold_sec = hs; blink_mode = bm; exclusive = ex;
    w = -1;
    for (int i = 0; i < N; i++) if (w < 0 && ev[i] && hs[i*W +: W] != 0) w = i;
    for (int i = 0; i < N; i++) begin
      if (r) begin
        rem[i] = 0; on[i] = 0;
      end else if (ev[i] && hs[i*W +: W] != 0 && (!ex || w == i)) begin
        rem[i] = int'(hs[i*W +: W]); on[i] = 1;
      end else if (ex && w >= 0) begin
        rem[i] = 0; on[i] = 0;
      end else if (tk && rem[i] > 0) begin
        rem[i]--; on[i] = !on[i];
      end
    end
    for (int i = 0; i < N; i++) begin
      e.act[i] = rem[i] > 0;
      e.led[i] = e.act[i] && (bm[i] ? on[i] : 1'b1);
    end
    e.any = |e.act;
    q.push_back(e);
    r = 0; tk = 0; ev = '0;
  endtask

  task automatic idle(int n);
    repeat (n) step();
  endtask

  task automatic tick_gap(int n, int gap);
    repeat (n) begin
      tk = 1; step(); idle(gap - 1);
    end
  endtask

  initial begin
    exp_t e;
    @(posedge clk);
    while (!done) begin
      @(posedge clk); #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("led", led, e.led);
        chk("active", active, e.act);
        chk("any_active", N'(any_active), N'(e.any));
      end
    end
  end

  initial begin
    r = 1; tk = 0; ex = 0; ev = '0; bm = '0; hs = '0;
    for (int i = 0; i < N; i++) begin rem[i] = 0; on[i] = 0; end
    step();
    idle(2);
    hs = {4'd3, 4'd3, 4'd2, 4'd3};
    ev = 4'b0001; step(); idle(3);
    tick_gap(3, 10); idle(3);
    bm = 4'b0010; ev = 4'b0010; step(); idle(2);
    tick_gap(2, 5); idle(2);
    ev = 4'b0100; step(); idle(2);
    tick_gap(2, 4);
    ev = 4'b0100; tk = 1; step(); idle(2);
    tick_gap(4, 3);
    ex = 1; hs = {4'd5, 4'd2, 4'd2, 4'd0};
    ev = 4'b1000; step(); idle(2);
    ev = 4'b0110; step(); idle(2);
    ev = 4'b0001; step(); idle(2);
    tick_gap(2, 3);
    ex = 0; hs = {4'd4, 4'd4, 4'd4, 4'd4};
    ev = 4'b0011; step(); idle(2);
    r = 1; ev = 4'b1100; tk = 1; step(); idle(2);
    for (int k = 0; k < 3000; k++) begin
      if (k % 200 == 0) ex = 1'($urandom_range(0, 1));
      if (k % 50 == 0) bm = N'($urandom);
      hs = (N*W)'($urandom) & {N{4'b0111}};
      ev = N'($urandom) & N'($urandom) & N'($urandom);
      tk = $urandom_range(0, 3) == 0;
      r = $urandom_range(0, 149) == 0;
      step();
    end
    idle(2);
    @(posedge clk); #2;
    done = 1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/led_status_bank.md
LED_STATUS_BANK -- requirements
Module: led_status_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent LED hold channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 4, width of each channel's hold-seconds value and counter.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port tick_1s  input  1  one-cycle strobe, once per second.
REQ-006 SHALL have port event_pulse  input  NUM_CH  per-channel one-cycle trigger.
REQ-007 SHALL have port hold_sec  input  NUM_CH*CNT_W  per-channel hold length in seconds; channel i at bits [i*CNT_W +: CNT_W].
REQ-008 SHALL have port blink_mode  input  NUM_CH  per-channel display mode: 0 = solid, 1 = blink.
REQ-009 SHALL have port exclusive  input  1  when 1, an accepted event cancels every other channel.
REQ-010 SHALL have port led  output  NUM_CH  registered LED drive per channel.
REQ-011 SHALL have port active  output  NUM_CH  registered per-channel hold-in-progress flag.
REQ-012 SHALL have port any_active  output  1  OR of active.

Function
REQ-013 Each channel SHALL hold a CNT_W-bit down-counter cnt, a blink phase bit ph, and active = (cnt != 0).
REQ-014 An event on channel i with hold_sec[i] != 0 SHALL be accepted: cnt <= hold_sec[i], ph <= 1 at that edge; active[i] and led[i] go high the cycle after event_pulse is sampled (latency 1).
REQ-015 An event with hold_sec[i] == 0 SHALL be ignored (no state change, no cancellation of other channels).
REQ-016 While cnt != 0, each tick_1s SHALL decrement cnt by 1 and toggle ph; cnt reaching 0 deasserts active and led on the following cycle.
REQ-017 Hold duration SHALL be exactly hold_sec ticks: led falls the cycle after the hold_sec-th tick_1s counted strictly after the accepting edge.
REQ-018 An event arriving while the channel is active SHALL retrigger: reload cnt from the current hold_sec, set ph to 1.
REQ-019 Event and tick_1s in the same cycle on a channel SHALL apply the event only (reload, no decrement, no toggle).
REQ-020 hold_sec SHALL be sampled only at acceptance; later changes SHALL NOT affect a running hold.
REQ-021 led[i] SHALL equal active[i] when blink_mode[i] = 0, and active[i] & ph[i] when blink_mode[i] = 1; blink_mode is combinationally applied to registered state and may change mid-hold.
REQ-022 With exclusive = 1, the lowest-index channel with an accepted event in a cycle SHALL win: it loads; all other channels (including other simultaneous events) are cleared to cnt = 0, ph = 0.
REQ-023 With exclusive = 1 and no accepted event, channels SHALL run independently.
REQ-024 With exclusive = 0, all channels SHALL be fully independent; simultaneous events on several channels all load.
REQ-025 cnt SHALL never wrap: tick_1s at cnt = 0 has no effect.

Reset
REQ-026 reset = 1 at an edge SHALL clear all cnt and ph to 0, forcing led, active, any_active to 0 the next cycle.
REQ-027 reset SHALL take priority over event_pulse and tick_1s in the same cycle, including mid-hold.

Verification
REQ-028 NUM_CH=4, hold_sec[0]=3, solid: event ch0, three ticks spaced 10 cycles -> led[0] high from cycle after event until cycle after 3rd tick; any_active follows.
REQ-029 hold_sec[1]=2, blink: event ch1, ticks -> led[1] pattern 1 (before tick1), 0 (after tick1), low after tick2; active[1] high throughout until tick2.
REQ-030 hold_sec[2]=3: event, 2 ticks, event again coincident with tick -> cnt reloads to 3; 3 further ticks required before led[2] falls.
REQ-031 exclusive=1, ch3 active, same-cycle events ch1 and ch2 (both hold 2) -> only ch1 active; ch2, ch3 cleared; hold_sec[0]=0 event on ch0 leaves ch1 untouched.
REQ-032 Two channels active, reset asserted together with an event and a tick -> all outputs 0 next cycle; event not accepted.
